sdram_dma_reader: RTL

SDRAM_DMA_READER -- requirements
Module: sdram_dma_reader

---
 rtl/sdram_dma_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sdram_dma_reader.sv
// Reads one buffer of 128-bit words from an Avalon-style pipelined SDRAM port
// into a downstream FIFO, throttled by outstanding-read count and FIFO space.
module sdram_dma_reader #(
    parameter int MAX_PENDING = 16
) (
    input  logic         CLK,
    input  logic         SRST,
    input  logic [27:0]  START_ADR,
    input  logic [27:0]  BUF_SIZE,
    input  logic         START,
    output logic [15:0]  DONE_CNT,
    output logic         BUSY,
    input  logic [10:0]  FIFO_SPACE,
    output logic [127:0] OUT_DATA,
    output logic         OUT_DV,
    output logic [27:0]  SDRAM_ADDRESS,
    output logic         SDRAM_READ,
    input  logic         SDRAM_WAITREQUEST,
    input  logic [127:0] SDRAM_READDATA,
    input  logic         SDRAM_READDATAVALID
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0] MAXP = 6'(MAX_PENDING);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [27:0]  r_addr;
    logic [27:0]  r_remaining;
    logic [27:0]  w_rem_nxt;
    logic [5:0]   r_pending;
    logic [5:0]   w_pend_nxt;
    logic         r_read;
    logic         r_out_dv;
    logic [127:0] r_out_data;
    logic [15:0]  r_done_cnt;
    logic         w_accept;
    logic         w_issue;
    logic         w_beat_ok;

    assign w_accept = r_read & ~SDRAM_WAITREQUEST;
    // Pending net of the beat already on OUT_DV; a beat with nothing left to cover is stale.
    assign w_beat_ok = (r_pending - {5'd0, r_out_dv}) != 6'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_pend_nxt  = r_pending + {5'd0, w_accept} - {5'd0, r_out_dv};
        if (w_accept && (r_remaining != '0)) begin
            w_rem_nxt = r_remaining - 28'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_rem_nxt   = BUF_SIZE;
                    w_state_nxt = (BUF_SIZE != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (w_accept && (r_remaining == 28'd1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_pending == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Launch decision uses the pending count of the cycle the request first appears.
    assign w_issue = (w_state_nxt == S_READ) && (w_rem_nxt != '0) && (w_pend_nxt < MAXP)
                     && (({6'd0, w_pend_nxt} + 12'd1) <= {1'b0, FIFO_SPACE});

    always_ff @(posedge CLK) begin
        if (SRST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pending   <= '0;
            r_read      <= 1'b0;
            r_out_dv    <= 1'b0;
            r_out_data  <= '0;
            r_done_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_pending   <= w_pend_nxt;
            if ((r_state == S_IDLE) && START) begin
                r_addr <= START_ADR;
            end else if (w_accept) begin
                r_addr <= r_addr + 28'd1;
            end
            if (r_read && SDRAM_WAITREQUEST) begin
                r_read <= 1'b1;
            end else begin
                r_read <= w_issue;
            end
            r_out_data <= SDRAM_READDATA;
            r_out_dv   <= SDRAM_READDATAVALID && w_beat_ok;
            if (r_state == S_DONE) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    assign DONE_CNT      = r_done_cnt;
    assign BUSY          = (r_state != S_IDLE);
    assign OUT_DATA      = r_out_data;
    assign OUT_DV        = r_out_dv;
    assign SDRAM_ADDRESS = r_addr;
    assign SDRAM_READ    = r_read;

endmodule
